// File: rtl/ped_crossing_ctrl.sv
// Pedestrian crossing controller slaved to the vehicle light FSM's signal code.
// Optional audible WALK cue on output beep when PED_AUDIO_EN is defined.
module ped_crossing_ctrl #(
  parameter int TICK_DIV   = 50000000,
  parameter int CLR_TIME   = 2,
  parameter int WALK_TIME  = 10,
  parameter int FLASH_TIME = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] veh_signal,
  input  logic       ped_btn,
  output logic       walk,
  output logic       dont_walk,
  output logic       req_pending,
  output logic [7:0] countdown,
`ifdef PED_AUDIO_EN
  output logic       beep,
`endif
  output logic       fault
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [2:0] {IDLE, CLEAR, WALK, FLASH, DONE} state_t;

  state_t        state;
  logic [PW-1:0] presc;
  logic [2:0]    prev_veh;
  logic          prev_btn;

  logic tick, veh_red, red_entry, illegal, press, timed;

  function automatic logic [7:0] sat8(input int v);
    return (v > 255) ? 8'd255 : 8'(v);
  endfunction

  always_comb begin
    tick      = (presc == PW'(TICK_DIV - 1));
    veh_red   = (veh_signal == 3'b000);
    red_entry = veh_red && (prev_veh != 3'b000);
    illegal   = (veh_signal > 3'b010);
    press     = ped_btn && !prev_btn;
    timed     = (state == CLEAR) || (state == WALK) || (state == FLASH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      walk        <= 1'b0;
      dont_walk   <= 1'b1;
      req_pending <= 1'b0;
      countdown   <= 8'd0;
      fault       <= 1'b0;
      presc       <= '0;
      prev_veh    <= 3'b000;
      prev_btn    <= 1'b0;
`ifdef PED_AUDIO_EN
      beep        <= 1'b0;
`endif
    end else begin
      prev_veh <= veh_signal;
      prev_btn <= ped_btn;
      presc    <= (timed && !tick) ? presc + PW'(1) : '0;
`ifdef PED_AUDIO_EN
      beep     <= 1'b0;
`endif
      // Requests made while pedestrians already cross are meaningless; WALK entry below clears.
      if (press && state != WALK) req_pending <= 1'b1;

      // Vehicles leaving RED under pedestrian right-of-way, or a corrupt code, forces failsafe.
      if (illegal || (timed && !veh_red)) begin
        state     <= IDLE;
        walk      <= 1'b0;
        dont_walk <= 1'b1;
        countdown <= 8'd0;
        fault     <= 1'b1;
        presc     <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            walk      <= 1'b0;
            dont_walk <= 1'b1;
            countdown <= 8'd0;
            if (!fault && red_entry && (req_pending || press)) begin
              state     <= CLEAR;
              countdown <= sat8(CLR_TIME);
              presc     <= '0;
            end
          end
          CLEAR: if (tick) begin
            if (countdown == 8'd1) begin
              state       <= WALK;
              countdown   <= sat8(WALK_TIME);
              walk        <= 1'b1;
              dont_walk   <= 1'b0;
              req_pending <= 1'b0;
            end else countdown <= countdown - 8'd1;
          end
          WALK: if (tick) begin
`ifdef PED_AUDIO_EN
            beep <= 1'b1;
`endif
            if (countdown == 8'd1) begin
              state     <= FLASH;
              countdown <= sat8(FLASH_TIME);
              walk      <= 1'b0;
              dont_walk <= 1'b1;
            end else countdown <= countdown - 8'd1;
          end
          FLASH: if (tick) begin
`ifdef PED_AUDIO_EN
            beep <= ~countdown[0];
`endif
            if (countdown == 8'd1) begin
              state     <= DONE;
              countdown <= 8'd0;
              dont_walk <= 1'b1;
            end else begin
              countdown <= countdown - 8'd1;
              dont_walk <= ~dont_walk;
            end
          end
          DONE: begin
            walk      <= 1'b0;
            dont_walk <= 1'b1;
            countdown <= 8'd0;
            if (!veh_red) state <= IDLE;
          end
          default: begin
            state     <= IDLE;
            walk      <= 1'b0;
            dont_walk <= 1'b1;
            countdown <= 8'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed scoreboard bench for ped_crossing_ctrl (TICK_DIV=4, CLR=2, WALK=5, FLASH=4).
module tb_ped_crossing_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] veh_signal;
  logic       ped_btn;
  logic       walk, dont_walk, req_pending, fault;
  logic [7:0] countdown;
`ifdef PED_AUDIO_EN
  logic       beep;
  int         beep_cnt  = 0;
  int         beep_wide = 0;
  logic       prev_beep = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [11:0] exp;
  } exp_t;
  exp_t sb[$];

  ped_crossing_ctrl #(.TICK_DIV(4), .CLR_TIME(2), .WALK_TIME(5), .FLASH_TIME(4)) dut (
    .clk(clk), .rst(rst), .veh_signal(veh_signal), .ped_btn(ped_btn),
    .walk(walk), .dont_walk(dont_walk), .req_pending(req_pending),
    .countdown(countdown),
`ifdef PED_AUDIO_EN
    .beep(beep),
`endif
    .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic clk1();
    @(posedge clk);
    #1;
`ifdef PED_AUDIO_EN
    if (beep) begin
      beep_cnt++;
      if (prev_beep) beep_wide++;
    end
    prev_beep = beep;
`endif
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) clk1();
  endtask

  // Expected {walk, dont_walk, req_pending, fault, countdown} after the next edge.
  task automatic cyc_exp(input string tag, input logic w, input logic dw,
                         input logic rp, input logic f, input logic [7:0] cd);
    exp_t e, got;
    logic [11:0] obs;
    e.tag = tag;
    e.exp = {w, dw, rp, f, cd};
    sb.push_back(e);
    clk1();
    got = sb.pop_front();
    obs = {walk, dont_walk, req_pending, fault, countdown};
    checks++;
    assert (obs === got.exp) else begin
      failures++;
      $error("FAIL %s observed w/dw/rp/f/cd=%b/%b/%b/%b/%0d expected %b/%b/%b/%b/%0d",
             got.tag, obs[11], obs[10], obs[9], obs[8], obs[7:0],
             got.exp[11], got.exp[10], got.exp[9], got.exp[8], got.exp[7:0]);
    end
  endtask

`ifdef PED_AUDIO_EN
  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; veh_signal = 3'b010; ped_btn = 1'b0;
    // Scenario 1: full service cycle
    cyc_exp("reset", 0, 1, 0, 0, 0);
`ifdef PED_AUDIO_EN
    chk_int("beep_reset", int'(beep), 0);
`endif
    rst = 1'b0;
    clk1();
    ped_btn = 1'b1;
    cyc_exp("press_latch", 0, 1, 1, 0, 0);
    ped_btn = 1'b0;
    veh_signal = 3'b000;
    cyc_exp("clear_entry", 0, 1, 1, 0, 2);
    run(6);
    cyc_exp("clear_last", 0, 1, 1, 0, 1);
    cyc_exp("walk_entry", 1, 0, 0, 0, 5);
`ifdef PED_AUDIO_EN
    beep_cnt = 0;
`endif
    run(18);
    cyc_exp("walk_last", 1, 0, 0, 0, 1);
    cyc_exp("flash_entry", 0, 1, 0, 0, 4);
`ifdef PED_AUDIO_EN
    chk_int("beep_walk", beep_cnt, 5);
`endif
    run(3);
    cyc_exp("flash_tgl1", 0, 0, 0, 0, 3);
    run(3);
    cyc_exp("flash_tgl2", 0, 1, 0, 0, 2);
    run(7);
    cyc_exp("done_entry", 0, 1, 0, 0, 0);
`ifdef PED_AUDIO_EN
    chk_int("beep_total", beep_cnt, 7);
    chk_int("beep_width", beep_wide, 0);
`endif

    // Scenario 2: RED without request, press held to next RED
    veh_signal = 3'b010;
    clk1();
    veh_signal = 3'b000;
    run(3);
    cyc_exp("red_nopress", 0, 1, 0, 0, 0);
    ped_btn = 1'b1;
    cyc_exp("press_midred", 0, 1, 1, 0, 0);
    ped_btn = 1'b0;
    run(4);
    cyc_exp("held", 0, 1, 1, 0, 0);
    veh_signal = 3'b001; clk1();
    veh_signal = 3'b010; clk1();
    veh_signal = 3'b000;
    cyc_exp("next_red", 0, 1, 1, 0, 2);
    run(7);
    cyc_exp("walk2", 1, 0, 0, 0, 5);

    // Scenario 3: vehicles leave RED during WALK
    run(7);
    cyc_exp("walk_cd3", 1, 0, 0, 0, 3);
    veh_signal = 3'b010;
    cyc_exp("abort", 0, 1, 0, 1, 0);
    clk1();
    veh_signal = 3'b000; ped_btn = 1'b1;
    cyc_exp("fault_red_press", 0, 1, 1, 1, 0);
    ped_btn = 1'b0;
    run(9);
    cyc_exp("fault_hold", 0, 1, 1, 1, 0);

    // Scenario 4: reset recovery and illegal code
    rst = 1'b1;
    cyc_exp("rst_clears", 0, 1, 0, 0, 0);
    rst = 1'b0;
    veh_signal = 3'b111;
    cyc_exp("illegal", 0, 1, 0, 1, 0);
    rst = 1'b1; veh_signal = 3'b010;
    cyc_exp("rst_again", 0, 1, 0, 0, 0);
    rst = 1'b0;

    // Scenario 5: same-cycle press, press in WALK, press in FLASH
    clk1();
    veh_signal = 3'b000; ped_btn = 1'b1;
    cyc_exp("same_cycle_press", 0, 1, 1, 0, 2);
    ped_btn = 1'b0;
    run(7);
    cyc_exp("walk3", 1, 0, 0, 0, 5);
    run(2);
    ped_btn = 1'b1;
    cyc_exp("walk_press", 1, 0, 0, 0, 5);
    ped_btn = 1'b0;
    run(16);
    cyc_exp("flash3", 0, 1, 0, 0, 4);
    clk1();
    ped_btn = 1'b1;
    cyc_exp("flash_press", 0, 1, 1, 0, 4);
    ped_btn = 1'b0;
    run(13);
    cyc_exp("done3", 0, 1, 1, 0, 0);
    veh_signal = 3'b010; clk1();
    veh_signal = 3'b000;
    cyc_exp("serviced", 0, 1, 1, 0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
